// File: rtl/dmi_debug_regs.sv
// rtl/dmi_debug_regs.sv - DMI debug-module register slave with abstract access-register engine
// Optional: define DMI_AUTOEXEC_EN to build abstractauto (0x18) with data0 autoexec.
module dmi_debug_regs #(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 32,
   parameter int NUM_GPR     = 8,
   parameter int CMD_LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dmi_req_valid,
   output logic              dmi_req_ready,
   input  logic [ADDR_W-1:0] dmi_addr,
   input  logic [DATA_W-1:0] dmi_wdata,
   input  logic [1:0]        dmi_op,
   output logic              dmi_rsp_valid,
   output logic [DATA_W-1:0] dmi_rdata,
   output logic [1:0]        dmi_resp,
   input  logic              hart_halted_i,
   output logic              haltreq_o,
   output logic              ndmreset_o
);

   localparam int CNT_W = $clog2(CMD_LATENCY + 1);
   localparam int IDX_W = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;
   localparam logic [15:0] GPR_BASE = 16'h1000;
   localparam logic [15:0] GPR_END  = 16'(32'h1000 + NUM_GPR);

   localparam logic [ADDR_W-1:0] A_DATA0      = ADDR_W'(7'h04);
   localparam logic [ADDR_W-1:0] A_DATA1      = ADDR_W'(7'h05);
   localparam logic [ADDR_W-1:0] A_DMCONTROL  = ADDR_W'(7'h10);
   localparam logic [ADDR_W-1:0] A_DMSTATUS   = ADDR_W'(7'h11);
   localparam logic [ADDR_W-1:0] A_ABSTRACTCS = ADDR_W'(7'h16);
   localparam logic [ADDR_W-1:0] A_COMMAND    = ADDR_W'(7'h17);
`ifdef DMI_AUTOEXEC_EN
   localparam logic [ADDR_W-1:0] A_ABSTRACTAUTO = ADDR_W'(7'h18);
`endif

   typedef enum logic {S_IDLE, S_RESP} state_t;
   state_t state, state_nxt;

   logic              accept, rd_req, wr_req;
   logic              hit_d0, hit_d1, hit_ctl, hit_acs, hit_cmd;
   logic              dm_off, busy_viol, eng_done;
   logic [DATA_W-1:0] data0, data1, rd_val;
   logic              dmactive, ndmreset, haltreq;
   logic [2:0]        cmderr, cmderr_nxt;
   logic              busy;
   logic [CNT_W-1:0]  cnt;
   logic              cmd_transfer, cmd_write;
   logic [IDX_W-1:0]  cmd_idx;
   logic [DATA_W-1:0] gpr [NUM_GPR];

   logic              launch_try, launch_go, l_ok, l_transfer, l_write;
   logic [IDX_W-1:0]  l_idx;

`ifdef DMI_AUTOEXEC_EN
   logic hit_auto, auto_data0, last_valid, relaunch;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      dmi_req_ready = 1'b0;
      dmi_rsp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            dmi_req_ready = 1'b1;
            if (dmi_req_valid) state_nxt = S_RESP;
         end
         S_RESP: begin
            dmi_rsp_valid = 1'b1;
            state_nxt     = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign accept  = dmi_req_valid && (state == S_IDLE);
   assign rd_req  = accept && (dmi_op == 2'd1);
   assign wr_req  = accept && (dmi_op == 2'd2);
   assign hit_d0  = (dmi_addr == A_DATA0);
   assign hit_d1  = (dmi_addr == A_DATA1);
   assign hit_ctl = (dmi_addr == A_DMCONTROL);
   assign hit_acs = (dmi_addr == A_ABSTRACTCS);
   assign hit_cmd = (dmi_addr == A_COMMAND);
`ifdef DMI_AUTOEXEC_EN
   assign hit_auto = (dmi_addr == A_ABSTRACTAUTO);
`endif

   // Clearing dmactive takes effect in the write's own edge so a running command cannot complete.
   assign dm_off    = !dmactive || (wr_req && hit_ctl && !dmi_wdata[0]);
   assign busy_viol = dmactive && busy &&
                      ((wr_req && (hit_d0 || hit_d1 || hit_cmd)) || (rd_req && (hit_d0 || hit_d1)));
   assign eng_done  = busy && (cnt == CNT_W'(1));

   always_comb begin
      launch_try = wr_req && hit_cmd && dmactive && !busy;
      l_transfer = dmi_wdata[17];
      l_write    = dmi_wdata[16];
      l_idx      = dmi_wdata[IDX_W-1:0];
      l_ok       = (dmi_wdata[31:24] == 8'd0) && (dmi_wdata[22:20] == 3'd2) &&
                   (!dmi_wdata[17] || ((dmi_wdata[15:0] >= GPR_BASE) && (dmi_wdata[15:0] < GPR_END)));
`ifdef DMI_AUTOEXEC_EN
      // The stored command already passed decode, so only the error/halt checks apply.
      if (relaunch) begin
         launch_try = 1'b1;
         l_transfer = cmd_transfer;
         l_write    = cmd_write;
         l_idx      = cmd_idx;
         l_ok       = 1'b1;
      end
`endif
   end

   assign launch_go = launch_try && (cmderr == 3'd0) && l_ok && hart_halted_i;

   always_comb begin
      cmderr_nxt = cmderr;
      if (wr_req && hit_acs && dmactive) cmderr_nxt = cmderr & ~dmi_wdata[10:8];
      if (busy_viol && (cmderr == 3'd0)) cmderr_nxt = 3'd1;
      if (launch_try && (cmderr == 3'd0)) begin
         if (!l_ok)               cmderr_nxt = 3'd2;
         else if (!hart_halted_i) cmderr_nxt = 3'd4;
      end
   end

   always_comb begin
      rd_val = '0;
      if ((dmi_op == 2'd1) && (dmactive || hit_ctl)) begin
         case (dmi_addr)
            A_DATA0:      rd_val = data0;
            A_DATA1:      rd_val = data1;
            A_DMCONTROL:  rd_val = {haltreq, 29'd0, ndmreset, dmactive};
            A_DMSTATUS:   rd_val = {20'd0, !hart_halted_i, !hart_halted_i, hart_halted_i,
                                    hart_halted_i, 1'b1, 3'd0, 4'd2};
            A_ABSTRACTCS: rd_val = {19'd0, busy, 1'b0, cmderr, 4'd0, 4'd2};
`ifdef DMI_AUTOEXEC_EN
            A_ABSTRACTAUTO: rd_val = {31'd0, auto_data0};
`endif
            default:      rd_val = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmi_rdata <= '0;
         dmi_resp  <= 2'd0;
      end else if (accept) begin
         dmi_rdata <= rd_val;
         dmi_resp  <= (dmi_op == 2'd3) ? 2'd2 : 2'd0;
      end else begin
         dmi_rdata <= '0;
         dmi_resp  <= 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmactive     <= 1'b0;
         ndmreset     <= 1'b0;
         haltreq      <= 1'b0;
         data0        <= '0;
         data1        <= '0;
         cmderr       <= 3'd0;
         busy         <= 1'b0;
         cnt          <= '0;
         cmd_transfer <= 1'b0;
         cmd_write    <= 1'b0;
         cmd_idx      <= '0;
      end else begin
         if (wr_req && hit_ctl) begin
            dmactive <= dmi_wdata[0];
            ndmreset <= dmi_wdata[0] & dmi_wdata[1];
            haltreq  <= dmi_wdata[0] & dmi_wdata[31];
         end
         if (dm_off) begin
            data0        <= '0;
            data1        <= '0;
            cmderr       <= 3'd0;
            busy         <= 1'b0;
            cnt          <= '0;
            cmd_transfer <= 1'b0;
            cmd_write    <= 1'b0;
            cmd_idx      <= '0;
         end else begin
            cmderr <= cmderr_nxt;
            if (wr_req && hit_d0 && !busy) data0 <= dmi_wdata;
            if (wr_req && hit_d1 && !busy) data1 <= dmi_wdata;
            if (launch_go) begin
               busy         <= 1'b1;
               cnt          <= CNT_W'(CMD_LATENCY);
               cmd_transfer <= l_transfer;
               cmd_write    <= l_write;
               cmd_idx      <= l_idx;
            end else if (busy) begin
               cnt <= cnt - 1'b1;
               if (eng_done) begin
                  busy <= 1'b0;
                  if (cmd_transfer && !cmd_write) data0 <= gpr[cmd_idx];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
      end else if (!dm_off && eng_done && cmd_transfer && cmd_write) begin
         gpr[cmd_idx] <= data0;
      end
   end

`ifdef DMI_AUTOEXEC_EN
   // Relaunch is issued in the response cycle, after the data0 access itself has landed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         auto_data0 <= 1'b0;
         last_valid <= 1'b0;
         relaunch   <= 1'b0;
      end else if (dm_off) begin
         auto_data0 <= 1'b0;
         last_valid <= 1'b0;
         relaunch   <= 1'b0;
      end else begin
         if (wr_req && hit_auto) auto_data0 <= dmi_wdata[0];
         if (launch_go) last_valid <= 1'b1;
         relaunch <= auto_data0 && last_valid && !busy && (rd_req || wr_req) && hit_d0;
      end
   end
`endif

   assign haltreq_o  = haltreq & dmactive;
   assign ndmreset_o = ndmreset & dmactive;

endmodule

// File: tb/tb_dmi_debug_regs.sv
// tb/tb_dmi_debug_regs.sv - directed and randomized bench for dmi_debug_regs against a transaction-level model
module tb_dmi_debug_regs;

   localparam int LAT  = 4;
   localparam int NGPR = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dmi_req_valid = 1'b0;
   logic        dmi_req_ready;
   logic [6:0]  dmi_addr = '0;
   logic [31:0] dmi_wdata = '0;
   logic [1:0]  dmi_op = '0;
   logic        dmi_rsp_valid;
   logic [31:0] dmi_rdata;
   logic [1:0]  dmi_resp;
   logic        hart_halted_i = 1'b0;
   logic        haltreq_o;
   logic        ndmreset_o;

   int n_asserts = 0;
   int n_fail    = 0;
   int cyc       = 0;

   dmi_debug_regs #(.ADDR_W(7), .DATA_W(32), .NUM_GPR(NGPR), .CMD_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
      .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_op(dmi_op),
      .dmi_rsp_valid(dmi_rsp_valid), .dmi_rdata(dmi_rdata), .dmi_resp(dmi_resp),
      .hart_halted_i(hart_halted_i), .haltreq_o(haltreq_o), .ndmreset_o(ndmreset_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: register contents plus the edge at which the running command was launched.
   logic [31:0] m_data0, m_data1;
   logic [31:0] m_gpr [NGPR];
   logic        m_dmactive, m_ndmreset, m_haltreq;
   logic [2:0]  m_cmderr;
   bit          m_eng, m_tr, m_wr;
   int          m_launch, m_idx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_data0 = 0; m_data1 = 0; m_dmactive = 0; m_ndmreset = 0; m_haltreq = 0;
      m_cmderr = 0; m_eng = 0; m_tr = 0; m_wr = 0; m_launch = 0; m_idx = 0;
      for (int i = 0; i < NGPR; i++) m_gpr[i] = 0;
   endtask

   // A command launched at edge L completes at edge L+LAT, after any access at that edge.
   task automatic m_settle(input int t);
      if (m_eng && t > m_launch + LAT) begin
         if (m_tr) begin
            if (m_wr) m_gpr[m_idx] = m_data0;
            else      m_data0 = m_gpr[m_idx];
         end
         m_eng = 0;
      end
   endtask

   task automatic m_flag_busy();
      if (m_cmderr == 0) m_cmderr = 1;
   endtask

   task automatic m_access(input int t, input logic [1:0] op, input logic [6:0] a,
                           input logic [31:0] w, input logic h,
                           output logic [31:0] er, output logic [1:0] ep);
      bit busy, legal;
      int regno;
      m_settle(t);
      busy = m_eng;
      er = 0;
      ep = (op == 2'd3) ? 2'd2 : 2'd0;
      if (op == 2'd1 && (m_dmactive || a == 7'h10)) begin
         case (a)
            7'h04: begin er = m_data0; if (busy) m_flag_busy(); end
            7'h05: begin er = m_data1; if (busy) m_flag_busy(); end
            7'h10: er = (32'(m_haltreq) << 31) | (32'(m_ndmreset) << 1) | 32'(m_dmactive);
            7'h11: er = 32'h82 | (h ? 32'h300 : 32'hC00);
            7'h16: er = 32'd2 | (32'(m_cmderr) << 8) | (busy ? 32'h1000 : 32'h0);
            default: er = 0;
         endcase
      end else if (op == 2'd2) begin
         if (a == 7'h10) begin
            m_dmactive = w[0];
            if (!w[0]) begin
               m_ndmreset = 0; m_haltreq = 0; m_data0 = 0; m_data1 = 0; m_cmderr = 0; m_eng = 0;
            end else begin
               m_ndmreset = w[1]; m_haltreq = w[31];
            end
         end else if (m_dmactive) begin
            case (a)
               7'h04: if (busy) m_flag_busy(); else m_data0 = w;
               7'h05: if (busy) m_flag_busy(); else m_data1 = w;
               7'h16: m_cmderr = m_cmderr & ~w[10:8];
               7'h17: begin
                  if (busy) m_flag_busy();
                  else if (m_cmderr == 0) begin
                     regno = int'(w[15:0]);
                     legal = (w[31:24] == 0) && (w[22:20] == 3'd2) &&
                             (!w[17] || (regno >= 4096 && regno < 4096 + NGPR));
                     if (!legal)  m_cmderr = 2;
                     else if (!h) m_cmderr = 4;
                     else begin
                        m_eng = 1; m_launch = t; m_tr = w[17]; m_wr = w[16]; m_idx = regno - 4096;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic req(input logic [1:0] op, input logic [6:0] a, input logic [31:0] w,
                      output logic [31:0] rd);
      logic [31:0] er;
      logic [1:0]  ep;
      int t;
      chk("ready_idle", dmi_req_ready, 1);
      dmi_req_valid = 1; dmi_op = op; dmi_addr = a; dmi_wdata = w;
      @(posedge clk);
      #1;
      t = cyc;
      dmi_req_valid = 0; dmi_op = 0;
      m_access(t, op, a, w, hart_halted_i, er, ep);
      chk("rsp_valid", dmi_rsp_valid, 1);
      chk("ready_in_rsp", dmi_req_ready, 0);
      chk($sformatf("rdata op%0d addr%02h", op, a), dmi_rdata, er);
      chk($sformatf("resp op%0d addr%02h", op, a), 32'(dmi_resp), 32'(ep));
      chk("haltreq_o", haltreq_o, m_dmactive & m_haltreq);
      chk("ndmreset_o", ndmreset_o, m_dmactive & m_ndmreset);
      rd = dmi_rdata;
      @(posedge clk);
      #1;
      chk("rsp_strobe_end", dmi_rsp_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, w;
      logic [7:0]  ct;
      logic [2:0]  sz;
      logic [15:0] rn;
      logic [6:0]  a;
      logic [1:0]  op;
      int          acc, k;
      logic [6:0]  amap [8];

      m_reset();
      idle(3);
      chk("rst_ready", dmi_req_ready, 1);
      chk("rst_rsp_valid", dmi_rsp_valid, 0);
      chk("rst_rdata", dmi_rdata, 0);
      chk("rst_resp", 32'(dmi_resp), 0);
      chk("rst_haltreq", haltreq_o, 0);
      chk("rst_ndmreset", ndmreset_o, 0);
      rst_n = 1;
      idle(1);

      req(2'd1, 7'h11, 0, rd);
      chk("dmstatus_inactive", rd, 32'h0);

      hart_halted_i = 1;
      req(2'd2, 7'h10, 32'h1, rd);
      req(2'd1, 7'h11, 0, rd);
      chk("dmstatus_halted", rd, 32'h382);

      req(2'd2, 7'h04, 32'hDEADBEEF, rd);
      req(2'd2, 7'h17, 32'h00231003, rd);
      req(2'd1, 7'h16, 0, rd);
      chk("busy_L+2", rd, 32'h1002);
      req(2'd1, 7'h16, 0, rd);
      chk("busy_L+4", rd, 32'h1002);
      req(2'd1, 7'h16, 0, rd);
      chk("idle_L+6", rd, 32'h0002);
      req(2'd2, 7'h04, 32'h0, rd);
      req(2'd2, 7'h17, 32'h00221003, rd);
      idle(LAT + 1);
      req(2'd1, 7'h04, 0, rd);
      chk("gpr_roundtrip", rd, 32'hDEADBEEF);

      req(2'd2, 7'h17, 32'h00231003, rd);
      req(2'd2, 7'h17, 32'h00231003, rd);
      req(2'd1, 7'h16, 0, rd);
      chk("cmderr_busy", rd, 32'h1102);
      idle(4);
      req(2'd2, 7'h16, 32'h100, rd);
      req(2'd1, 7'h16, 0, rd);
      chk("cmderr_w1c", rd, 32'h2);

      req(2'd2, 7'h17, 32'h00231010, rd);
      req(2'd1, 7'h16, 0, rd);
      chk("cmderr_regno", rd, 32'h202);
      req(2'd2, 7'h16, 32'h700, rd);
      hart_halted_i = 0;
      req(2'd2, 7'h17, 32'h00231003, rd);
      req(2'd1, 7'h16, 0, rd);
      chk("cmderr_running", rd, 32'h402);
      req(2'd2, 7'h16, 32'h700, rd);
      hart_halted_i = 1;

      req(2'd3, 7'h04, 32'h12345678, rd);
      chk("op3_rdata", rd, 32'h0);

      dmi_req_valid = 1; dmi_op = 2'd0; dmi_addr = 7'h04;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         logic r;
         r = dmi_req_ready;
         @(posedge clk);
         #1;
         if (r) acc++;
         chk("b2b_strobe", dmi_rsp_valid, r);
      end
      dmi_req_valid = 0;
      chk("b2b_accepts", acc, 6);
      idle(1);

      req(2'd2, 7'h10, 32'h80000003, rd);
      req(2'd2, 7'h17, 32'h00231003, rd);
      #3;
      rst_n = 0;
      #1;
      chk("async_rst_ready", dmi_req_ready, 1);
      chk("async_rst_rsp", dmi_rsp_valid, 0);
      chk("async_rst_haltreq", haltreq_o, 0);
      chk("async_rst_ndmreset", ndmreset_o, 0);
      m_reset();
      @(posedge clk);
      #1;
      rst_n = 1;
      idle(1);
      req(2'd2, 7'h10, 32'h1, rd);
      req(2'd2, 7'h17, 32'h00221003, rd);
      idle(LAT + 1);
      req(2'd1, 7'h04, 0, rd);
      chk("gpr_cleared_by_reset", rd, 32'h0);

      amap[0] = 7'h04; amap[1] = 7'h05; amap[2] = 7'h10; amap[3] = 7'h11;
      amap[4] = 7'h16; amap[5] = 7'h17; amap[6] = 7'h18; amap[7] = 7'h00;
      for (int n = 0; n < 400; n++) begin
         k = $urandom_range(0, 99);
         op = (k < 5) ? 2'd0 : (k < 10) ? 2'd3 : (k < 50) ? 2'd1 : 2'd2;
         a = amap[$urandom_range(0, 7)];
         if (a == 7'h00) a = 7'($urandom);
         w = $urandom;
         if (a == 7'h10) begin
            if ($urandom_range(0, 19) == 0) w = 32'h0;
            else w = {1'($urandom), 29'd0, 1'($urandom), 1'b1};
         end else if (a == 7'h17) begin
            ct = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
            rn = ($urandom_range(0, 19) == 0) ? 16'($urandom)
                                              : 16'(32'h1000 + $urandom_range(0, NGPR + 1));
            w = {ct, 1'b0, sz, 2'b00, 1'($urandom), 1'($urandom), rn};
         end
         if ($urandom_range(0, 19) == 0) hart_halted_i = ~hart_halted_i;
         req(op, a, w, rd);
         idle($urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
